// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, frames 11-bit device-to-host
// words and decodes E0/F0 prefixes into a keycode history with press/release strobes.

// Synchronizes one raw PS/2 pin and debounces it: the output only follows the
// pin after LEN consecutive samples disagree with the current filtered value.
module ps2_pin_filter #(
    parameter int LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // 2-FF synchronizer followed by the run-length filter; idle level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ps2_keycode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keycode,
    output logic        flag,
    output logic        brk_flag,
    output logic        ext,
    output logic        err,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic          clk_f, data_f, clk_f_q, fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          ext_pend, brk_pend;
    logic          start_err, frame_ok, frame_err, tmo;

    ps2_pin_filter #(.LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_clk),
        .filt  (clk_f)
    );

    ps2_pin_filter #(.LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_data),
        .filt  (data_f)
    );

    assign fall = clk_f_q & ~clk_f;
    assign busy = (state != IDLE);

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Frame sequencing; a fall coinciding with timeout expiry wins over the timeout
    always_comb begin
        state_nx  = state;
        start_err = 1'b0;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        tmo       = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_f) state_nx = DATA;
                    else         start_err = 1'b1;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                end
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    if (data_f && ((^shreg) ^ par)) frame_ok  = 1'b1;
                    else                            frame_err = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo      = 1'b1;
            state_nx = IDLE;
        end
    end

    // Bit capture, timeout counting and edge history
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f_q <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            clk_f_q <= clk_f;
            if (state == IDLE || fall || tmo) tmo_cnt <= '0;
            else                              tmo_cnt <= tmo_cnt + 1'b1;
            if (state == IDLE) bit_cnt <= '0;
            if (fall && state == DATA) begin
                shreg   <= {data_f, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall && state == PARITY) par <= data_f;
        end
    end

    // Byte decoder: history shift, prefix latches and one-cycle strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            keycode  <= '0;
            flag     <= 1'b0;
            brk_flag <= 1'b0;
            ext      <= 1'b0;
            err      <= 1'b0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else begin
            flag     <= 1'b0;
            brk_flag <= 1'b0;
            err      <= start_err | frame_err | tmo;
            if (frame_ok) begin
                keycode <= {keycode[23:0], shreg};
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext      <= ext_pend;
                    flag     <= ~brk_pend;
                    brk_flag <= brk_pend;
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: bit-banged PS/2 frames, scoreboard of expected strobes.
module tb_ps2_keycode_rx;
    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int HALF = 40;

    localparam logic [1:0] K_FLAG = 2'd0, K_BRK = 2'd1, K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        ext;
        logic [31:0] kc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [31:0] keycode;
    logic        flag, brk_flag, ext, err, busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    exp_t sb[$];

    ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .flag     (flag),
        .brk_flag (brk_flag),
        .ext      (ext),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if (!reset && (flag || brk_flag || err)) begin
            exp_t e;
            logic [1:0] k;
            k = err ? K_ERR : (brk_flag ? K_BRK : K_FLAG);
            n_checks++;
            if (int'(flag) + int'(brk_flag) + int'(err) > 1) begin
                n_errors++;
                $display("FAIL strobe_overlap flag=%0b brk=%0b err=%0b", flag, brk_flag, err);
            end
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe kind=%0d keycode=%h at cyc %0d", k, keycode, cyc);
            end else begin
                e = sb.pop_front();
                n_checks += 2;
                if (k !== e.kind) begin
                    n_errors++;
                    $display("FAIL strobe_kind got %0d expected %0d", k, e.kind);
                end
                if (keycode !== e.kc) begin
                    n_errors++;
                    $display("FAIL keycode got %h expected %h", keycode, e.kc);
                end
                if (ext !== e.ext) begin
                    n_errors++;
                    $display("FAIL ext got %0b expected %0b", ext, e.ext);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic e, input logic [31:0] kc);
        exp_t x;
        x.kind = kind;
        x.ext  = e;
        x.kc   = kc;
        sb.push_back(x);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_clk(3 * HALF);
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s_missing_strobes got %0d pending expected 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clk(5);
        n_checks += 2;
        if (keycode !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_keycode got %h expected 0", keycode);
        end
        if ({flag, brk_flag, ext, err, busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got %b expected 00000", {flag, brk_flag, ext, err, busy});
        end
        reset = 1'b0;
        wait_clk(20);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_busy got %0b expected 0", busy);
        end
    endtask

    task automatic test_make();
        push_exp(K_FLAG, 1'b0, 32'h0000001C);
        send_frame(8'h1C, 0, 0);
        check_drained("make");
    endtask

    task automatic test_break();
        pulse_reset();
        push_exp(K_FLAG, 1'b0, 32'h0000001C);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        push_exp(K_BRK, 1'b0, 32'h001CF01C);
        send_frame(8'h1C, 0, 0);
        check_drained("break");
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 0, 0);
        push_exp(K_FLAG, 1'b1, 32'hF01CE075);
        send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        push_exp(K_BRK, 1'b1, 32'h75E0F075);
        send_frame(8'h75, 0, 0);
        check_drained("extended");
    endtask

    task automatic test_errors();
        push_exp(K_ERR, 1'b1, 32'h75E0F075);
        send_frame(8'h1C, 1, 0);
        push_exp(K_ERR, 1'b1, 32'h75E0F075);
        send_frame(8'h1C, 0, 1);
        push_exp(K_FLAG, 1'b0, 32'hE0F07516);
        send_frame(8'h16, 0, 0);
        check_drained("errors");
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        bit   seen;
        int   seen_cyc;
        logic busy_at;
        b = 8'h45;
        seen = 0;
        seen_cyc = -1;
        busy_at = 1'b1;
        push_exp(K_ERR, 1'b0, 32'hE0F07516);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_busy_midframe got %0b expected 1", busy);
        end
        for (int i = 0; i < TO + FL + 100; i++) begin
            @(negedge clk);
            if (err) begin
                seen = 1;
                seen_cyc = cyc;
                busy_at = busy;
                break;
            end
        end
        n_checks += 3;
        if (!seen) begin
            n_errors++;
            $display("FAIL timeout_err_missing got none expected err pulse");
        end
        // raw fall -> 2 sync + FL filter -> fall acted on -> TO idle cycles
        if (seen_cyc != last_fall_cyc + 3 + FL + TO) begin
            n_errors++;
            $display("FAIL timeout_latency got cyc %0d expected %0d", seen_cyc, last_fall_cyc + 3 + FL + TO);
        end
        if (busy_at !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_busy got %0b expected 0", busy_at);
        end
        wait_clk(5);
        push_exp(K_FLAG, 1'b0, 32'hF0751645);
        send_frame(8'h45, 0, 0);
        check_drained("timeout");
    endtask

    task automatic test_glitch();
        bit busy_seen;
        busy_seen = 0;
        ps2_clk = 1'b0;
        wait_clk(FL - 1);
        ps2_clk = 1'b1;
        for (int i = 0; i < 4 * FL + 10; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        n_checks++;
        if (busy_seen) begin
            n_errors++;
            $display("FAIL glitch_busy got 1 expected 0");
        end
        check_drained("glitch");
    endtask

    task automatic test_reset_midframe();
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL midframe_busy got %0b expected 1", busy);
        end
        ps2_data = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (keycode !== 32'h0) begin
            n_errors++;
            $display("FAIL midframe_reset_keycode got %h expected 0", keycode);
        end
        if ({flag, brk_flag, ext, err, busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL midframe_reset_outputs got %b expected 00000", {flag, brk_flag, ext, err, busy});
        end
        reset = 1'b0;
        wait_clk(10);
        push_exp(K_FLAG, 1'b0, 32'h0000001E);
        send_frame(8'h1E, 0, 0);
        check_drained("midframe");
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_errors();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        wait_clk(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
